// File: rtl/gardner_pkg.sv
// Shared definitions for the Gardner timing recovery chain.
//   ONE / HALF : Q1.15 constants
//   DATA_W     : loop-filter / step word width
//   MU_W       : fractional interval width
//   sat_clamp  : clamps an 18-bit signed value into [lo, hi], returns DATA_W bits
package gardner_pkg;

  localparam int ONE    = 32768;
  localparam int HALF   = 16384;
  localparam int DATA_W = 16;
  localparam int MU_W   = 16;

  // lo/hi are expected to be non-negative and fit in DATA_W bits.
  function automatic logic [DATA_W-1:0] sat_clamp(input logic signed [17:0] x,
                                                  input logic signed [17:0] lo,
                                                  input logic signed [17:0] hi);
    logic signed [17:0] r;
    if (x < lo)      r = lo;
    else if (x > hi) r = hi;
    else             r = x;
    return DATA_W'(r);
  endfunction

endpackage

// File: rtl/timing_nco_if.sv
// Bundle between the timing NCO and its neighbours.
//   en, loop_err_valid, loop_err : sample valid and loop-filter steering
//   strobe, mu, sym_phase, step  : interpolator request, interval, TED phase, debug step
// master drives the inputs of the NCO; slave is the NCO itself.
interface timing_nco_if;
  import gardner_pkg::*;

  logic                     en;
  logic                     loop_err_valid;
  logic signed [DATA_W-1:0] loop_err;
  logic                     strobe;
  logic [MU_W-1:0]          mu;
  logic                     sym_phase;
  logic [DATA_W-1:0]        step;

  modport master (
    output en, loop_err_valid, loop_err,
    input  strobe, mu, sym_phase, step
  );

  modport slave (
    input  en, loop_err_valid, loop_err,
    output strobe, mu, sym_phase, step
  );

endinterface

// File: rtl/timing_nco.sv
// Timing-control NCO for Gardner symbol timing recovery.
// Modulo-1 decrementing counter (Q1.15, 15-bit) advanced on each valid sample.
// Each underflow issues a one-cycle strobe with mu = min(2*eta_old, 32767) and
// toggles sym_phase (on-time / midpoint). The step is nominal + loop error,
// clamped to [STEP_MIN, STEP_MAX].
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : timing_nco_if.slave (en, loop_err_valid, loop_err in;
//           strobe, mu, sym_phase, step out)
module timing_nco
  import gardner_pkg::*;
#(
  parameter int NOMINAL_STEP = 16384,
  parameter int STEP_MIN     = 12288,
  parameter int STEP_MAX     = 20480
) (
  input  logic         clk,
  input  logic         rst_n,
  timing_nco_if.slave  bus
);

  localparam logic signed [17:0] NOM_S = 18'(NOMINAL_STEP);
  localparam logic signed [17:0] MIN_S = 18'(STEP_MIN);
  localparam logic signed [17:0] MAX_S = 18'(STEP_MAX);
  localparam logic [14:0]        ETA_RST = 15'h7fff;
  localparam logic [MU_W-1:0]    MU_MAX  = MU_W'(ONE - 1);

  logic [14:0]        eta_q, eta_d;
  logic [DATA_W-1:0]  step_q, step_d;
  logic               strobe_q, strobe_d;
  logic [MU_W-1:0]    mu_q, mu_d;
  logic               sym_phase_q, sym_phase_d;

  logic signed [17:0] step_raw;
  logic signed [16:0] diff;
  logic               underflow;
  logic [MU_W-1:0]    eta_x2;

  always_comb begin
    step_raw = NOM_S + {{2{bus.loop_err[DATA_W-1]}}, bus.loop_err};
    step_d   = step_q;
    if (bus.loop_err_valid) step_d = sat_clamp(step_raw, MIN_S, MAX_S);
  end

  // The counter always sees step_q, so a step loaded this cycle applies on the
  // next en. Underflow wraps by +1.0, which is just the low 15 bits of diff.
  always_comb begin
    diff        = signed'({2'b00, eta_q}) - signed'({1'b0, step_q});
    underflow   = diff[16];
    eta_x2      = {eta_q, 1'b0};
    eta_d       = eta_q;
    strobe_d    = 1'b0;
    mu_d        = mu_q;
    sym_phase_d = sym_phase_q;
    if (bus.en) begin
      eta_d = 15'(diff);
      if (underflow) begin
        strobe_d    = 1'b1;
        mu_d        = eta_x2[MU_W-1] ? MU_MAX : eta_x2;
        sym_phase_d = ~sym_phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eta_q       <= ETA_RST;
      step_q      <= DATA_W'(NOMINAL_STEP);
      strobe_q    <= 1'b0;
      mu_q        <= '0;
      sym_phase_q <= 1'b1;
    end else begin
      eta_q       <= eta_d;
      step_q      <= step_d;
      strobe_q    <= strobe_d;
      mu_q        <= mu_d;
      sym_phase_q <= sym_phase_d;
    end
  end

  assign bus.strobe    = strobe_q;
  assign bus.mu        = mu_q;
  assign bus.sym_phase = sym_phase_q;
  assign bus.step      = step_q;

endmodule
